stream_cipher_ctrl: RTL and testbench

Session controller that sequences a word-serial XOR stream-cipher datapath. On `start` it seeds a Galois LFSR keystream generator from a one-time key. It then accepts exactly `length` data words over a valid/ready input and emits each word XORed with the current keystream word over a valid/ready output. It signals `done` when the last word has left the block. It sits between the message source and the ciphertext sink and serves both encryption and decryption, since the XOR operation is symmetric.

---
 rtl/stream_cipher_ctrl.sv | 149 ++++++++++++++
 tb/tb_stream_cipher_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stream_cipher_ctrl
// Purpose  : Session controller for a word-serial XOR stream cipher. On start
//            it seeds a Galois LFSR from a one-time key, accepts exactly
//            `length` words on a valid/ready input, emits each word XORed
//            with the current keystream word on a valid/ready output, and
//            pulses done once the last word has left the block. The same
//            path encrypts and decrypts.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start, key, length - session request (sampled in IDLE only)
//            abort              - drop the session (RUN/DRAIN only)
//            in_valid/in_ready/in_data    - input word handshake
//            out_valid/out_ready/out_data - output word handshake
//            busy, done, word_count       - session status
// Revision : 1.0 - initial release
// ============================================================================
module stream_cipher_ctrl #(
   parameter int                DATA_W = 32,
   parameter int                LEN_W  = 8,
   parameter logic [DATA_W-1:0] TAPS   = 32'h8020_0003
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] key,
   input  logic [LEN_W-1:0]  length,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  word_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [DATA_W-1:0] r_ks;
   logic [LEN_W-1:0]  r_remaining;
   logic              w_accept;
   logic              w_abort;
   logic [DATA_W-1:0] w_ks_next;

   // Galois step: shift right, fold the feedback mask in when a one drops out.
   assign w_ks_next = (r_ks >> 1) ^ (r_ks[0] ? TAPS : '0);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and handshake decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      w_accept     = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = (length == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            busy     = 1'b1;
            w_abort  = abort;
            // Single output register: refill it in the same cycle it drains.
            in_ready = !out_valid || out_ready;
            // Abort wins over a same-cycle accept so no keystream is consumed.
            w_accept = in_valid && in_ready && !abort;
            if (abort) begin
               w_next_state = S_IDLE;
            end else if (w_accept && (r_remaining == LEN_W'(1))) begin
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy    = 1'b1;
            w_abort = abort;
            if (abort) begin
               w_next_state = S_IDLE;
            end else if (!out_valid || out_ready) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Keystream, counters and output register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ks        <= '0;
         r_remaining <= '0;
         word_count  <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            // An all-zero seed would lock the LFSR at zero forever.
            r_ks        <= (key == '0) ? DATA_W'(1) : key;
            r_remaining <= length;
            word_count  <= '0;
         end
         if (w_abort) begin
            out_valid <= 1'b0;
         end else if (w_accept) begin
            out_data    <= in_data ^ r_ks;
            out_valid   <= 1'b1;
            r_ks        <= w_ks_next;
            r_remaining <= r_remaining - LEN_W'(1);
            word_count  <= word_count + LEN_W'(1);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stream_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_cipher_ctrl
// Purpose  : Self-checking bench for stream_cipher_ctrl. A reference model
//            precomputes the keystream for each session and keeps a queue of
//            expected output words; handshakes are randomized.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_cipher_ctrl;

   localparam int          DATA_W = 32;
   localparam int          LEN_W  = 8;
   localparam logic [31:0] TAPS   = 32'h8020_0003;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [DATA_W-1:0] key;
   logic [LEN_W-1:0]  length;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              busy;
   logic              done;
   logic [LEN_W-1:0]  word_count;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [31:0] src  [256];
   logic [31:0] orig [256];
   logic [31:0] got  [$];

   always #5 clk = ~clk;

   stream_cipher_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TAPS(TAPS)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .key        (key),
      .length     (length),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .word_count (word_count)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
   endfunction

   // One complete session with randomized valid/ready; returns the cycle on
   // which done was first seen (1 = first cycle after start was sampled).
   task automatic session(input logic [31:0] k, input int len, input int vld_pct,
                          input int rdy_pct, output int done_cyc);
      logic [31:0] ks [$];
      logic [31:0] exp_q [$];
      logic [31:0] s, prev_data;
      bit          prev_stall, finished, bsy;
      int          acc, dn, cyc;
      s = (k == 0) ? 32'd1 : k;
      for (int j = 0; j < len; j++) begin
         ks.push_back(s);
         s = lfsr_step(s);
      end
      got.delete();
      @(negedge clk);
      start = 1'b1; key = k; length = len[LEN_W-1:0];
      in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
      @(negedge clk);
      start = 1'b0;
      acc = 0; dn = 0; done_cyc = -1; prev_stall = 0; prev_data = '0; finished = 0; cyc = 1;
      while (!finished && cyc < len * 20 + 50) begin
         bsy       = busy;
         in_valid  = (acc < len) && ($urandom_range(0, 99) < vld_pct);
         in_data   = in_valid ? src[acc] : $urandom;
         out_ready = ($urandom_range(0, 99) < rdy_pct);
         // Start requests while a session runs must be ignored.
         start     = bsy && ($urandom_range(0, 3) == 0);
         key       = $urandom;
         length    = LEN_W'($urandom);
         #1;
         if (dn > 0) begin
            check_val("done_once", {63'd0, done}, 64'd0);
            check_val("busy_after_done", {63'd0, busy}, 64'd0);
            finished = 1;
         end else begin
            check_val("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            check_val("in_ready", {63'd0, in_ready},
                      {63'd0, (acc < len) && (!out_valid || out_ready)});
            check_val("busy", {63'd0, busy}, {63'd0, !done});
            if (prev_stall) check_val("hold_data", {32'd0, out_data}, {32'd0, prev_data});
            if (out_valid && out_ready) begin
               if (exp_q.size() != 0) check_val("out_data", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
               got.push_back(out_data);
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(src[acc] ^ ks[acc]);
               acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
               dn++;
               done_cyc = cyc;
               check_val("accepted_at_done", 64'(acc), 64'(len));
               check_val("pending_at_done", 64'(exp_q.size()), 64'd0);
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check_val("session_done_seen", {63'd0, finished}, 64'd1);
      check_val("word_count", {56'd0, word_count}, 64'(len[LEN_W-1:0]));
   endtask

   initial begin
      int dc;
      int len;
      rst = 1'b1; start = 1'b0; abort = 1'b0; key = '0; length = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("rst_out_data", {32'd0, out_data}, 64'd0);
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_done", {63'd0, done}, 64'd0);
      check_val("rst_word_count", {56'd0, word_count}, 64'd0);
      check_val("rst_in_ready", {63'd0, in_ready}, 64'd0);
      rst = 1'b0;

      // Known keystream from seed 1, then seed 0 which must behave the same.
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 3; i++) src[i] = 32'h0;
         session(p == 0 ? 32'd1 : 32'd0, 3, 100, 100, dc);
         check_val("ks_word0", {32'd0, got.size() > 0 ? got[0] : 32'hx}, 64'h0000_0001);
         check_val("ks_word1", {32'd0, got.size() > 1 ? got[1] : 32'hx}, 64'h8020_0003);
         check_val("ks_word2", {32'd0, got.size() > 2 ? got[2] : 32'hx}, 64'hC030_0002);
         check_val("ks_done_cycle", 64'(dc), 64'd5);
      end

      // Round trip: ciphertext fed back under the same key gives plaintext.
      for (int i = 0; i < 4; i++) begin src[i] = $urandom; orig[i] = src[i]; end
      session(32'hDEAD_BEEF, 4, 70, 60, dc);
      for (int i = 0; i < 4; i++) src[i] = (got.size() > i) ? got[i] : 32'h0;
      session(32'hDEAD_BEEF, 4, 70, 60, dc);
      for (int i = 0; i < 4; i++)
         check_val("round_trip", {32'd0, got.size() > i ? got[i] : 32'hx}, {32'd0, orig[i]});

      // Heavy backpressure.
      for (int i = 0; i < 3; i++) src[i] = $urandom;
      session($urandom, 3, 100, 15, dc);

      // Zero-length session: straight to DONE.
      session($urandom, 0, 100, 100, dc);
      check_val("zero_len_done_cycle", 64'(dc), 64'd1);

      // Random sessions.
      for (int r = 0; r < 6; r++) begin
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) src[i] = $urandom;
         session($urandom, len, $urandom_range(30, 100), $urandom_range(30, 100), dc);
      end

      // Abort after 2 of 5 words, with a competing accept in the abort cycle.
      @(negedge clk);
      start = 1'b1; key = $urandom; length = 8'd5;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
      @(negedge clk);
      in_data = $urandom;
      @(negedge clk);
      check_val("wc_before_abort", {56'd0, word_count}, 64'd2);
      abort = 1'b1; in_data = $urandom;
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      #1;
      check_val("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("abort_busy", {63'd0, busy}, 64'd0);
      check_val("abort_done", {63'd0, done}, 64'd0);
      check_val("abort_word_count", {56'd0, word_count}, 64'd2);
      @(negedge clk);
      check_val("abort_no_done_later", {63'd0, done}, 64'd0);
      check_val("abort_idle_in_ready", {63'd0, in_ready}, 64'd0);

      // Reset in the middle of a session.
      start = 1'b1; key = $urandom; length = 8'd5;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = $urandom; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      check_val("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("midrst_out_data", {32'd0, out_data}, 64'd0);
      check_val("midrst_busy", {63'd0, busy}, 64'd0);
      check_val("midrst_word_count", {56'd0, word_count}, 64'd0);
      check_val("midrst_in_ready", {63'd0, in_ready}, 64'd0);

      // Full throughput at maximum length.
      for (int i = 0; i < 255; i++) src[i] = $urandom;
      session($urandom, 255, 100, 100, dc);
      check_val("full_done_cycle", 64'(dc), 64'd257);
      check_val("full_words_out", 64'(got.size()), 64'd255);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
